pattern_tx: RTL and testbench

Serial pattern transmitter: the sending end of the single-bit serial stream consumed by the sequence detector. Accepts a bit pattern (1..MAX_LEN bits) with a repeat count through a start/busy handshake and shifts it out MSB-first, one bit per clock, with an optional zero gap between repetitions. Counts completed repetitions and presents the count on two 7-bit outputs for the board's seven-segment displays. Drives the detector's `in` directly on the bench or board.

---
 rtl/pattern_tx.sv | 160 ++++++++++++++++
 tb/tb_pattern_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_tx.sv
// pattern_tx: MSB-first serial pattern transmitter with repeat count, optional inter-repetition gap and repetition counter.
// Define PATTERN_TX_SEG_EN to drive A/B as seven-segment tens/ones digits instead of a binary count.
module pattern_tx #(
    parameter int MAX_LEN = 16,
    parameter int GAP     = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MAX_LEN-1:0] data,
    input  logic [4:0]         len,
    input  logic [3:0]         reps,
    output logic               out,
    output logic               out_valid,
    output logic               busy,
    output logic               done,
    output logic [6:0]         A,
    output logic [6:0]         B
);
    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

    localparam logic [4:0] LEN_MAX  = 5'(MAX_LEN);
    localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t             state;
    logic [MAX_LEN-1:0] pat_al;
    logic [MAX_LEN-1:0] shreg;
    logic [4:0]         len_reg;
    logic [4:0]         bits_left;
    logic [3:0]         reps_left;
    logic [3:0]         gap_left;
    logic [6:0]         count;

    logic [4:0]         eff_len;
    logic [3:0]         eff_reps;
    logic [4:0]         align_sh;
    logic [MAX_LEN-1:0] data_al;
    logic [6:0]         count_next;
    logic [6:0]         a_next;
    logic [6:0]         b_next;

    // The pattern is left-aligned on load so the bit on the wire is always the shift register MSB.
    always_comb begin
        eff_len    = (len > LEN_MAX) ? LEN_MAX : len;
        eff_reps   = (reps == 4'd0) ? 4'd1 : reps;
        align_sh   = LEN_MAX - eff_len;
        data_al    = data << align_sh;
        count_next = (count == 7'd99) ? 7'd0 : count + 7'd1;
    end

`ifdef PATTERN_TX_SEG_EN
    localparam logic [6:0] DISP_RST = 7'h7E;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'h7E;
            4'd1:    seg7 = 7'h30;
            4'd2:    seg7 = 7'h6D;
            4'd3:    seg7 = 7'h79;
            4'd4:    seg7 = 7'h33;
            4'd5:    seg7 = 7'h5B;
            4'd6:    seg7 = 7'h5F;
            4'd7:    seg7 = 7'h70;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h7B;
            default: seg7 = 7'h00;
        endcase
    endfunction

    always_comb begin
        a_next = seg7(4'(count_next / 7'd10));
        b_next = seg7(4'(count_next % 7'd10));
    end
`else
    localparam logic [6:0] DISP_RST = 7'h00;

    always_comb begin
        a_next = count_next;
        b_next = 7'h00;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            pat_al    <= '0;
            shreg     <= '0;
            len_reg   <= '0;
            bits_left <= '0;
            reps_left <= '0;
            gap_left  <= '0;
            count     <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            A         <= DISP_RST;
            B         <= DISP_RST;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && len != 5'd0) begin
                        pat_al    <= data_al;
                        len_reg   <= eff_len;
                        reps_left <= eff_reps;
                        out       <= data_al[MAX_LEN-1];
                        shreg     <= data_al << 1;
                        bits_left <= eff_len - 5'd1;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (bits_left != 5'd0) begin
                        out       <= shreg[MAX_LEN-1];
                        shreg     <= shreg << 1;
                        bits_left <= bits_left - 5'd1;
                    end else begin
                        // Last bit of a repetition is on the wire this cycle.
                        count     <= count_next;
                        A         <= a_next;
                        B         <= b_next;
                        reps_left <= reps_left - 4'd1;
                        if (reps_left == 4'd1) begin
                            out       <= 1'b0;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_IDLE;
                        end else if (GAP > 0) begin
                            out       <= 1'b0;
                            out_valid <= 1'b0;
                            gap_left  <= GAP_LAST;
                            state     <= ST_GAP;
                        end else begin
                            out       <= pat_al[MAX_LEN-1];
                            shreg     <= pat_al << 1;
                            bits_left <= len_reg - 5'd1;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_left != 4'd0) begin
                        gap_left <= gap_left - 4'd1;
                    end else begin
                        out       <= pat_al[MAX_LEN-1];
                        shreg     <= pat_al << 1;
                        bits_left <= len_reg - 5'd1;
                        out_valid <= 1'b1;
                        state     <= ST_SHIFT;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: drives a GAP=0 and a GAP=2 pattern_tx with directed and random requests,
// comparing every cycle against a queue of expected cycles built from the frame rules.
`timescale 1ns/1ps
module tb_pattern_tx;
    localparam int GAP0 = 0;
    localparam int GAP1 = 2;

    typedef struct packed {
        logic       out;
        logic       valid;
        logic       busy;
        logic       done;
        logic [6:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_v [2];
    logic [15:0] data_v  [2];
    logic [4:0]  len_v   [2];
    logic [3:0]  reps_v  [2];
    logic        out_w   [2];
    logic        valid_w [2];
    logic        busy_w  [2];
    logic        done_w  [2];
    logic [6:0]  a_w     [2];
    logic [6:0]  b_w     [2];

    int   checks_total  = 0;
    int   checks_passed = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   model_cnt [2];
    int   accepted  [2];

    always #5 clk = ~clk;

    pattern_tx #(.MAX_LEN(16), .GAP(GAP0)) dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .data(data_v[0]), .len(len_v[0]),
        .reps(reps_v[0]), .out(out_w[0]), .out_valid(valid_w[0]), .busy(busy_w[0]),
        .done(done_w[0]), .A(a_w[0]), .B(b_w[0])
    );

    pattern_tx #(.MAX_LEN(16), .GAP(GAP1)) dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .data(data_v[1]), .len(len_v[1]),
        .reps(reps_v[1]), .out(out_w[1]), .out_valid(valid_w[1]), .busy(busy_w[1]),
        .done(done_w[1]), .A(a_w[1]), .B(b_w[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        if (observed === expected) checks_passed++;
        else $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
    endtask

`ifdef PATTERN_TX_SEG_EN
    localparam logic [6:0] SEG [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    localparam logic [6:0] EXP_A42 = 7'h33;
    localparam logic [6:0] EXP_B42 = 7'h6D;
    function automatic logic [13:0] dispExp(input int c);
        return {SEG[c / 10], SEG[c % 10]};
    endfunction
`else
    localparam logic [6:0] EXP_A42 = 7'd42;
    localparam logic [6:0] EXP_B42 = 7'h00;
    function automatic logic [13:0] dispExp(input int c);
        return {7'(c), 7'h00};
    endfunction
`endif

    function automatic int gapOf(input int k);
        return (k == 0) ? GAP0 : GAP1;
    endfunction

    function automatic int qSize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    task automatic pushRec(input int k, input logic o, input logic v, input logic b, input logic d);
        exp_t e;
        e.out = o; e.valid = v; e.busy = b; e.done = d; e.cnt = 7'(model_cnt[k]);
        if (k == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Expected wire activity of one accepted frame, one entry per clock cycle.
    task automatic pushFrame(input int k, input logic [15:0] d, input logic [4:0] l, input logic [3:0] r);
        int nbits;
        int nreps;
        nbits = (l > 5'd16) ? 16 : int'(l);
        nreps = (r == 4'd0) ? 1 : int'(r);
        for (int rep = 0; rep < nreps; rep++) begin
            for (int i = 0; i < nbits; i++)
                pushRec(k, 1'((d >> (nbits - 1 - i)) & 16'd1), 1'b1, 1'b1, 1'b0);
            model_cnt[k] = (model_cnt[k] + 1) % 100;
            if (rep < nreps - 1)
                for (int g = 0; g < gapOf(k); g++) pushRec(k, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        pushRec(k, 1'b0, 1'b0, 1'b0, 1'b1);
        accepted[k]++;
    endtask

    task automatic popExpected(input int k, output exp_t e);
        e.out = 1'b0; e.valid = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.cnt = 7'(model_cnt[k]);
        if (k == 0 && q0.size() > 0) e = q0.pop_front();
        if (k == 1 && q1.size() > 0) e = q1.pop_front();
    endtask

    task automatic applyStimulus(input int k, input logic st, input logic [15:0] d, input logic [4:0] l, input logic [3:0] r);
        start_v[k] = st; data_v[k] = d; len_v[k] = l; reps_v[k] = r;
    endtask

    // A DUT is idle in the current cycle exactly when its expected queue is empty.
    task automatic stepCycle();
        exp_t e;
        for (int k = 0; k < 2; k++)
            if (reset && qSize(k) == 0 && start_v[k] && len_v[k] != 5'd0)
                pushFrame(k, data_v[k], len_v[k], reps_v[k]);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            popExpected(k, e);
            checkOutput($sformatf("ctl%0d", k), {28'd0, out_w[k], valid_w[k], busy_w[k], done_w[k]},
                        {28'd0, e.out, e.valid, e.busy, e.done});
            checkOutput($sformatf("disp%0d", k), {18'd0, a_w[k], b_w[k]}, {18'd0, dispExp(int'(e.cnt))});
        end
    endtask

    task automatic doReset();
        #2 reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("rst_ctl%0d", k), {28'd0, out_w[k], valid_w[k], busy_w[k], done_w[k]}, 32'd0);
            checkOutput($sformatf("rst_disp%0d", k), {18'd0, a_w[k], b_w[k]}, {18'd0, dispExp(0)});
        end
        q0.delete();
        q1.delete();
        model_cnt[0] = 0; model_cnt[1] = 0;
        accepted[0] = 0;  accepted[1] = 0;
        stepCycle();
        reset = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        start_v[0] = 1'b0;
        start_v[1] = 1'b0;
        while ((qSize(0) > 0 || qSize(1) > 0) && n < 400) begin
            stepCycle();
            n++;
        end
        checkOutput("drain", qSize(0) + qSize(1), 0);
    endtask

    task automatic runFramesTo(input int target);
        int guard = 0;
        while ((accepted[0] < target || accepted[1] < target) && guard < 600) begin
            for (int k = 0; k < 2; k++)
                applyStimulus(k, accepted[k] < target, 16'($urandom), 5'd1, 4'd1);
            stepCycle();
            guard++;
        end
        drain();
        checkOutput("frames0", accepted[0], target);
        checkOutput("frames1", accepted[1], target);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0;
        model_cnt[0] = 0; model_cnt[1] = 0;
        accepted[0] = 0;  accepted[1] = 0;
        for (int k = 0; k < 2; k++) applyStimulus(k, 1'b0, 16'h0, 5'd0, 4'd0);
        @(negedge clk);
        doReset();

        // Directed frames, then start held high with changing data while busy.
        applyStimulus(0, 1'b1, 16'h000B, 5'd4, 4'd1);
        applyStimulus(1, 1'b1, 16'h0006, 5'd3, 4'd3);
        stepCycle();
        for (int c = 0; c < 16; c++) begin
            for (int k = 0; k < 2; k++) data_v[k] = 16'($urandom);
            stepCycle();
        end
        drain();

        // Zero length is ignored; oversize length clamps; zero reps means one.
        for (int k = 0; k < 2; k++) applyStimulus(k, 1'b1, 16'hFFFF, 5'd0, 4'd2);
        for (int c = 0; c < 4; c++) stepCycle();
        for (int k = 0; k < 2; k++) applyStimulus(k, 1'b1, 16'($urandom), 5'd20, 4'd0);
        stepCycle();
        drain();

        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 2; k++)
                applyStimulus(k, $urandom_range(0, 3) == 0, 16'($urandom),
                              5'($urandom_range(0, 20)), 4'($urandom_range(0, 3)));
            stepCycle();
        end
        drain();

        // Reset in the middle of a frame abandons it.
        for (int k = 0; k < 2; k++) applyStimulus(k, 1'b1, 16'($urandom), 5'd16, 4'd2);
        stepCycle();
        for (int k = 0; k < 2; k++) start_v[k] = 1'b0;
        for (int c = 0; c < 5; c++) stepCycle();
        doReset();
        for (int c = 0; c < 3; c++) stepCycle();

        runFramesTo(42);
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("a42_%0d", k), {25'd0, a_w[k]}, {25'd0, EXP_A42});
            checkOutput($sformatf("b42_%0d", k), {25'd0, b_w[k]}, {25'd0, EXP_B42});
        end
        runFramesTo(100);
        for (int k = 0; k < 2; k++)
            checkOutput($sformatf("wrap%0d", k), {18'd0, a_w[k], b_w[k]}, {18'd0, dispExp(0)});

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
